// File: rtl/cnn_pool_pkg.sv
// cnn_pool_pkg: state encoding and constants shared by the 2x2 average-pool sequencer.
package cnn_pool_pkg;
    typedef enum logic [3:0] {IDLE, CLR, ACC0, ACC1, ACC2, ACC3, CAPT, OUT, DONE} pool_state_e;
    localparam logic [31:0] FP_ZERO = 32'h0000_0000;
endpackage

// File: rtl/avgpool_addr_gen.sv
// avgpool_addr_gen: walks 2x2 windows in row-major order and emits the four element addresses.
module avgpool_addr_gen
    import cnn_pool_pkg::*;
#(
    parameter int FM_W   = 28,
    parameter int FM_H   = 28,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              adv,
    output logic [ADDR_W-1:0] e0,
    output logic [ADDR_W-1:0] e1,
    output logic [ADDR_W-1:0] e2,
    output logic [ADDR_W-1:0] e3,
    output logic              last
);
    localparam logic [ADDR_W-1:0] W       = ADDR_W'(FM_W);
    localparam logic [ADDR_W-1:0] TWO     = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] COL_END = ADDR_W'(FM_W - 2);
    localparam logic [ADDR_W-1:0] ROW_END = ADDR_W'(FM_H - 2);
    logic [ADDR_W-1:0] row_q, row_d, col_q, col_d, base_q, base_d;
    logic              col_wrap;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q  <= '0;
            col_q  <= '0;
            base_q <= '0;
        end else begin
            row_q  <= row_d;
            col_q  <= col_d;
            base_q <= base_d;
        end
    end
    // base tracks row*FM_W + col incrementally; a row wrap jumps from (FM_W-2) to the next row pair
    always_comb begin
        col_wrap = col_q == COL_END;
        last     = col_wrap && row_q == ROW_END;
        col_d    = clr ? '0 : adv ? (col_wrap ? '0 : col_q + TWO) : col_q;
        row_d    = clr ? '0 : (adv && col_wrap) ? row_q + TWO : row_q;
        base_d   = clr ? '0 : adv ? base_q + (col_wrap ? W + TWO : TWO) : base_q;
        e0       = base_q;
        e1       = base_q + 1'b1;
        e2       = base_q + W;
        e3       = base_q + W + 1'b1;
    end
endmodule

// File: rtl/avgpool_window_seq.sv
// avgpool_window_seq: sequences 2x2 windows of a feature map through an external averager
// and hands each pooled value downstream with a valid/ready handshake.
module avgpool_window_seq
    import cnn_pool_pkg::*;
#(
    parameter int FM_W   = 28,
    parameter int FM_H   = 28,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              go,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [31:0]       rd_data,
    output logic [31:0]       pool_in,
    output logic              pool_start,
    input  logic [31:0]       pool_avg,
    output logic [31:0]       out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);
    pool_state_e       state_q, state_d;
    logic [31:0]       out_data_q;
    logic [ADDR_W-1:0] e0, e1, e2, e3;
    logic              last, clr, hs;
    avgpool_addr_gen #(.FM_W(FM_W), .FM_H(FM_H), .ADDR_W(ADDR_W)) u_addr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .adv   (hs),
        .e0    (e0),
        .e1    (e1),
        .e2    (e2),
        .e3    (e3),
        .last  (last)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            out_data_q <= FP_ZERO;
        end else begin
            state_q    <= state_d;
            out_data_q <= (state_q == CAPT) ? pool_avg : out_data_q;
        end
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = go ? CLR : IDLE;
            CLR:     state_d = ACC0;
            ACC0:    state_d = ACC1;
            ACC1:    state_d = ACC2;
            ACC2:    state_d = ACC3;
            ACC3:    state_d = CAPT;
            CAPT:    state_d = OUT;
            OUT:     state_d = out_ready ? (last ? DONE : CLR) : OUT;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    // read data arrives one cycle after its address, so each ACC state consumes the previous state's address
    always_comb begin
        clr        = state_q == IDLE && go;
        hs         = state_q == OUT && out_ready;
        busy       = state_q != IDLE;
        done       = state_q == DONE;
        pool_start = state_q inside {ACC0, ACC1, ACC2, ACC3};
        pool_in    = pool_start ? rd_data : FP_ZERO;
        rd_addr    = (state_q == CLR)  ? e0 :
                     (state_q == ACC0) ? e1 :
                     (state_q == ACC1) ? e2 :
                     (state_q == ACC2) ? e3 : '0;
        out_valid  = state_q == OUT;
        out_last   = out_valid && last;
        out_data   = out_data_q;
    end
endmodule

// File: tb/tb_avgpool_window_seq.sv
// tb_avgpool_window_seq: drives a 4x4 and a 28x28 sequencer against a real-valued averager and memory model.
module tb_avgpool_window_seq;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int AW = 10;
    localparam int NW = (W / 2) * (H / 2);

    logic          clk = 1'b0, rst_n = 1'b0, go = 1'b0, out_ready = 1'b0;
    logic          busy, done, pool_start, out_valid, out_last;
    logic [AW-1:0] rd_addr;
    logic [31:0]   rd_data = '0, pool_in, pool_avg, out_data;

    logic          go2 = 1'b0, out_ready2 = 1'b1;
    logic          busy2, done2, pool_start2, out_valid2, out_last2;
    logic [AW-1:0] rd_addr2;
    logic [31:0]   rd_data2 = '0, pool_in2, pool_avg2, out_data2;

    int            n_chk = 0, n_err = 0;
    logic [31:0]   mem [W*H];
    logic [31:0]   outq [$];
    real           acc = 0.0, acc2 = 0.0;

    always #5 clk = ~clk;

    avgpool_window_seq #(.FM_W(W), .FM_H(H), .ADDR_W(AW)) u_dut (
        .clk(clk), .rst_n(rst_n), .go(go), .busy(busy), .done(done), .rd_addr(rd_addr),
        .rd_data(rd_data), .pool_in(pool_in), .pool_start(pool_start), .pool_avg(pool_avg),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
    );

    avgpool_window_seq u_dut28 (
        .clk(clk), .rst_n(rst_n), .go(go2), .busy(busy2), .done(done2), .rd_addr(rd_addr2),
        .rd_data(rd_data2), .pool_in(pool_in2), .pool_start(pool_start2), .pool_avg(pool_avg2),
        .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready2), .out_last(out_last2)
    );

    function automatic real f2r(input logic [31:0] b);
        real v;
        int  e;
        e = int'(b[30:23]);
        if (e == 0) return 0.0;
        v = 1.0 + real'(b[22:0]) / 8388608.0;
        for (int i = 127; i < e; i++) v = v * 2.0;
        for (int i = e; i < 127; i++) v = v / 2.0;
        return b[31] ? -v : v;
    endfunction

    function automatic logic [31:0] r2f(input real v);
        real  m;
        int   e;
        logic s;
        if (v == 0.0) return 32'h0;
        s = v < 0.0;
        m = s ? -v : v;
        e = 127;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0) begin m = m * 2.0; e--; end
        return {s, 8'(e), 23'($rtoi((m - 1.0) * 8388608.0))};
    endfunction

    // memory with one-cycle read latency and an averager that adds a quarter of its input per enabled clock
    always @(posedge clk) begin
        rd_data  <= (int'(rd_addr) < W * H) ? mem[rd_addr[3:0]] : 32'hDEAD_BEEF;
        rd_data2 <= (int'(rd_addr2) < 784) ? 32'h3F80_0000 : 32'h0;
        acc      <= pool_start ? acc + f2r(pool_in) / 4.0 : 0.0;
        acc2     <= pool_start2 ? acc2 + f2r(pool_in2) / 4.0 : 0.0;
    end
    always_comb begin
        pool_avg  = r2f(acc);
        pool_avg2 = r2f(acc2);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_rd_addr"}, 32'(rd_addr), 0);
        chk({tag, "_out_valid"}, 32'(out_valid), 0);
        chk({tag, "_out_last"}, 32'(out_last), 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_pool_start"}, 32'(pool_start), 0);
        chk({tag, "_pool_in"}, pool_in, 0);
    endtask

    // One full map on the 4x4 instance: every window is CLR, ACC0..ACC3, CAPT, then OUT until accepted.
    task automatic run_map(input int wmax, input bit fixed, input bit go_out);
        int          b, k;
        int          ea [4];
        logic [31:0] exp_avg, exp_in;
        outq.delete();
        chk("idle_before_go", 32'(busy), 0);
        @(negedge clk) go = 1'b1;
        @(negedge clk) go = 1'b0;
        for (int w = 0; w < NW; w++) begin
            b  = (w / (W / 2)) * 2 * W + (w % (W / 2)) * 2;
            ea = '{b, b + 1, b + W, b + W + 1};
            exp_avg = r2f((f2r(mem[ea[0]]) + f2r(mem[ea[1]]) + f2r(mem[ea[2]]) + f2r(mem[ea[3]])) / 4.0);
            for (int j = 0; j < 6; j++) begin
                out_ready = 1'($urandom_range(0, 1));
                go = go_out & 1'($urandom_range(0, 1));
                exp_in = 32'h0;
                if (j >= 1 && j <= 4) exp_in = mem[ea[j-1]];
                chk("rd_addr", 32'(rd_addr), (j < 4) ? 32'(ea[j]) : 32'h0);
                chk("pool_start", 32'(pool_start), (j >= 1 && j <= 4) ? 32'h1 : 32'h0);
                chk("pool_in", pool_in, exp_in);
                chk("busy_win", 32'(busy), 1);
                chk("valid_low_win", 32'(out_valid), 0);
                @(negedge clk);
            end
            k = fixed ? wmax : int'($urandom_range(0, wmax));
            for (int i = 0; i <= k; i++) begin
                out_ready = (i == k);
                go = go_out;
                chk("out_valid", 32'(out_valid), 1);
                chk("out_data", out_data, exp_avg);
                chk("out_last", 32'(out_last), (w == NW - 1) ? 32'h1 : 32'h0);
                chk("rd_addr_out", 32'(rd_addr), 0);
                chk("pool_start_out", 32'(pool_start), 0);
                if (i == k) outq.push_back(out_data);
                @(negedge clk);
            end
            out_ready = 1'b0;
            go = 1'b0;
        end
        chk("done_pulse", 32'(done), 1);
        chk("done_valid_low", 32'(out_valid), 0);
        @(negedge clk);
        chk("done_clear", 32'(done), 0);
        chk("idle_after", 32'(busy), 0);
        chk("out_count", 32'(outq.size()), NW);
    endtask

    initial begin
        int outs, dones;
        #2;
        chk_zero_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < W * H; i++) mem[i] = r2f(real'(i + 1));
        run_map(0, 1'b1, 1'b0);
        chk("seq_out0", outq[0], 32'h4060_0000);
        chk("seq_out1", outq[1], 32'h40B0_0000);
        chk("seq_out2", outq[2], 32'h4138_0000);
        chk("seq_out3", outq[3], 32'h4158_0000);

        for (int i = 0; i < W * H; i++) mem[i] = r2f(real'($urandom_range(1, 255)));
        run_map(5, 1'b0, 1'b1);
        run_map(5, 1'b1, 1'b0);

        out_ready = 1'b1;
        @(negedge clk) go = 1'b1;
        @(negedge clk) go = 1'b0;
        repeat (10) @(negedge clk);
        chk("acc2_win1_addr", 32'(rd_addr), 7);
        chk("acc2_win1_start", 32'(pool_start), 1);
        #2 rst_n = 1'b0;
        #1 chk_zero_outputs("midmap_reset");
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("post_reset_valid", 32'(out_valid), 0);
            chk("post_reset_busy", 32'(busy), 0);
        end
        out_ready = 1'b0;
        for (int i = 0; i < W * H; i++) mem[i] = r2f(real'($urandom_range(1, 255)));
        run_map(3, 1'b0, 1'b0);

        outs  = 0;
        dones = 0;
        @(negedge clk) go2 = 1'b1;
        @(negedge clk) go2 = 1'b0;
        for (int cyc = 1; cyc <= 1400; cyc++) begin
            if (out_valid2) begin
                chk("fm28_spacing", 32'(cyc), 32'(7 * (outs + 1)));
                chk("fm28_data", out_data2, 32'h3F80_0000);
                chk("fm28_last", 32'(out_last2), (outs == 195) ? 32'h1 : 32'h0);
                outs++;
            end
            if (done2) begin
                chk("fm28_done_cycle", 32'(cyc), 7 * 196 + 1);
                dones++;
            end
            @(negedge clk);
        end
        chk("fm28_outputs", 32'(outs), 196);
        chk("fm28_dones", 32'(dones), 1);
        chk("fm28_idle", 32'(busy2), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/avgpool_window_seq.md
AVGPOOL_WINDOW_SEQ -- requirements
Module: avgpool_window_seq

Interface
REQ-001 SHALL have parameter FM_W, default 28: feature-map width in elements; must be even and at least 2.
REQ-002 SHALL have parameter FM_H, default 28: feature-map height in elements; must be even and at least 2.
REQ-003 SHALL have parameter ADDR_W, default 10: read-address width; 2^ADDR_W must be at least FM_W*FM_H.
REQ-004 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port go  in  1  start-of-map pulse; sampled only in IDLE.
REQ-007 SHALL have port busy  out  1  high in every state except IDLE.
REQ-008 SHALL have port done  out  1  one-cycle pulse after the last output handshake.
REQ-009 SHALL have port rd_addr  out  ADDR_W  feature-map memory read address.
REQ-010 SHALL have port rd_data  in  32  IEEE-754 single; valid the cycle after rd_addr is presented (1-cycle latency).
REQ-011 SHALL have port pool_in  out  32  operand to the 2x2 averager.
REQ-012 SHALL have port pool_start  out  1  averager enable; low clears the accumulator, high accumulates pool_in/4 each clock.
REQ-013 SHALL have port pool_avg  in  32  averager accumulator value.
REQ-014 SHALL have port out_data  out  32  pooled result, registered.
REQ-015 SHALL have port out_valid  out  1  out_data is valid.
REQ-016 SHALL have port out_ready  in  1  downstream accepts; handshake = out_valid & out_ready.
REQ-017 SHALL have port out_last  out  1  qualifies the final window of the map.

Function
REQ-018 SHALL implement states IDLE, CLR, ACC0, ACC1, ACC2, ACC3, CAPT, OUT, DONE.
REQ-019 IDLE: on go=1, SHALL reset the window row/col counters to (0,0) and go to CLR; otherwise stay in IDLE.
REQ-020 Window (r,c), with r,c stepping by 2, SHALL use base address b = r*FM_W + c and element addresses e0=b, e1=b+1, e2=b+FM_W, e3=b+FM_W+1.
REQ-021 CLR: pool_start=0, rd_addr=e0.
REQ-022 ACC0: pool_start=1, rd_addr=e1. ACC1: pool_start=1, rd_addr=e2. ACC2: pool_start=1, rd_addr=e3. ACC3: pool_start=1.
REQ-023 In ACC0..ACC3, pool_in SHALL equal rd_data combinationally. In all other states, pool_in SHALL be 32'h0000_0000.
REQ-024 rd_addr SHALL be 0 in states that do not present an address.
REQ-025 CAPT: SHALL load out_data with pool_avg on the clock edge that leaves CAPT, drive pool_start=0, then go to OUT.
REQ-026 OUT: SHALL hold out_valid=1 and keep out_data stable until the handshake. out_last SHALL be 1 only when r=FM_H-2 and c=FM_W-2.
REQ-027 On the handshake, the column SHALL advance by 2. At c=FM_W-2 the column SHALL wrap to 0 and the row SHALL advance by 2. The next state SHALL be CLR, or DONE after the last window.
REQ-028 DONE: done=1 for exactly one cycle, then IDLE.
REQ-029 Minimum throughput SHALL be 7 cycles per window. A map SHALL produce (FM_W/2)*(FM_H/2) outputs in row-major window order.
REQ-030 go asserted while busy SHALL be ignored.
REQ-031 out_ready asserted outside OUT SHALL have no effect.
REQ-032 SHALL perform no floating-point arithmetic; all arithmetic is address/counter integer math, computed without overflow at ADDR_W bits.

Reset
REQ-033 rst_n=0 SHALL force, asynchronously: state=IDLE, counters=0, out_data=0, out_valid=0, out_last=0, done=0, busy=0, pool_start=0, rd_addr=0.
REQ-034 Reset mid-map SHALL abandon the map. After release, no output SHALL appear until a new go.

Structure
REQ-035 The state enum and FP_ZERO (32'h0000_0000) SHALL reside in shared package cnn_pool_pkg.
REQ-036 Window counters and e0..e3 generation SHALL reside in sub-module avgpool_addr_gen. The averager itself is instantiated outside this block.

Verification
REQ-037 Scenario: 4x4 map, values 1.0..16.0 row-major, averager model attached, out_ready=1 -> outputs 3.5, 5.5, 11.5, 13.5; out_last on the 4th only; done one cycle later.
REQ-038 Scenario: FM_W=FM_H=4, go -> rd_addr sequence 0,1,4,5 | 2,3,6,7 | 8,9,12,13 | 10,11,14,15; pool_start low exactly in CLR/CAPT/OUT/IDLE.
REQ-039 Scenario: out_ready held 0 for 5 cycles in OUT -> out_valid stays 1, out_data unchanged, no new rd_addr issued.
REQ-040 Scenario: rst_n pulsed low during ACC2 of window 2 -> all outputs 0 immediately; subsequent go restarts from address 0.
REQ-041 Scenario: go pulsed during OUT -> no effect on sequence or output count.
REQ-042 Scenario: all elements 32'h3F80_0000 (1.0), 28x28 -> 196 outputs, each 32'h3F80_0000, back-to-back at 7 cycles each.
